// File: rtl/pwm_pkg.sv
`default_nettype none
// +---------------------------------------------------------------------+
// | pwm_pkg : shared constants, state enums and byte-strobe helper for   |
// |           the PWM AXI4-Lite register block.                          |
// | Revision: 1.0                                                        |
// +---------------------------------------------------------------------+
package pwm_pkg;

  localparam int CTRL_OFS     = 'h00;
  localparam int PRESCALE_OFS = 'h04;
  localparam int INFO_OFS     = 'h0C;
  localparam int CH_BASE      = 'h10;
  localparam int CH_STRIDE    = 8;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [0:0] {
    W_IDLE = 1'b0,
    W_RESP = 1'b1
  } wr_state_e;

  typedef enum logic [0:0] {
    R_IDLE = 1'b0,
    R_DATA = 1'b1
  } rd_state_e;

  typedef enum logic [2:0] {
    SEL_NONE     = 3'd0,
    SEL_CTRL     = 3'd1,
    SEL_PRESCALE = 3'd2,
    SEL_INFO     = 3'd3,
    SEL_PERIOD   = 3'd4,
    SEL_DUTY     = 3'd5
  } reg_sel_e;

  function automatic logic [31:0] f_apply_wstrb(input logic [31:0] i_old,
                                                input logic [31:0] i_data,
                                                input logic [3:0]  i_strb);
    logic [31:0] w_res;
    w_res = i_old;
    for (int b = 0; b < 4; b++) begin
      if (i_strb[b]) w_res[8*b +: 8] = i_data[8*b +: 8];
    end
    return w_res;
  endfunction

endpackage
`default_nettype wire

// File: rtl/pwm_reg_decode.sv
`default_nettype none
// +---------------------------------------------------------------------+
// | pwm_reg_decode : byte address -> register select, channel index and  |
// |                  valid flag. One instance per AXI direction.         |
// | Revision: 1.0                                                        |
// +---------------------------------------------------------------------+
module pwm_reg_decode
  import pwm_pkg::*;
#(
  parameter int ADDR_WIDTH   = 8,
  parameter int NUM_CHANNELS = 4,
  parameter int CH_W         = 2
) (
  input  logic [ADDR_WIDTH-1:0] i_addr,
  output reg_sel_e              o_sel,
  output logic [CH_W-1:0]       o_ch,
  output logic                  o_valid
);

  logic [ADDR_WIDTH-1:0] w_addr;
  logic [ADDR_WIDTH-1:0] w_ofs;

  always_comb begin
    w_addr = i_addr & ~ADDR_WIDTH'(3);
    w_ofs  = w_addr - ADDR_WIDTH'(CH_BASE);
    o_sel  = SEL_NONE;
    o_ch   = '0;
    if (w_addr == ADDR_WIDTH'(CTRL_OFS)) begin
      o_sel = SEL_CTRL;
    end else if (w_addr == ADDR_WIDTH'(PRESCALE_OFS)) begin
      o_sel = SEL_PRESCALE;
    end else if (w_addr == ADDR_WIDTH'(INFO_OFS)) begin
      o_sel = SEL_INFO;
    end else if ((w_addr >= ADDR_WIDTH'(CH_BASE)) &&
                 (w_ofs < ADDR_WIDTH'(NUM_CHANNELS * CH_STRIDE))) begin
      // Each channel owns a PERIOD/DUTY word pair; bit 2 picks the DUTY word.
      o_sel = w_ofs[2] ? SEL_DUTY : SEL_PERIOD;
      o_ch  = CH_W'(w_ofs / ADDR_WIDTH'(CH_STRIDE));
    end
    o_valid = (o_sel != SEL_NONE);
  end

endmodule
`default_nettype wire

// File: rtl/pwm_axi_regs.sv
`default_nettype none
// +---------------------------------------------------------------------+
// | pwm_axi_regs : AXI4-Lite register file feeding pwm_core with enable,|
// |   prescaler and per-channel period/duty. Define PWM_REGS_SHADOW_EN   |
// |   to stage PRESCALE/PERIOD/DUTY in shadows applied by CTRL.COMMIT.   |
// | Revision: 1.0                                                        |
// +---------------------------------------------------------------------+
module pwm_axi_regs
  import pwm_pkg::*;
#(
  parameter int NUM_CHANNELS    = 4,
  parameter int REG_WIDTH       = 16,
  parameter int PRESCALER_WIDTH = 16,
  parameter int ADDR_WIDTH      = 8
) (
  input  logic                                   i_clk,
  input  logic                                   i_resetn,
  input  logic [ADDR_WIDTH-1:0]                  s_axi_awaddr,
  input  logic                                   s_axi_awvalid,
  output logic                                   s_axi_awready,
  input  logic [31:0]                            s_axi_wdata,
  input  logic [3:0]                             s_axi_wstrb,
  input  logic                                   s_axi_wvalid,
  output logic                                   s_axi_wready,
  output logic [1:0]                             s_axi_bresp,
  output logic                                   s_axi_bvalid,
  input  logic                                   s_axi_bready,
  input  logic [ADDR_WIDTH-1:0]                  s_axi_araddr,
  input  logic                                   s_axi_arvalid,
  output logic                                   s_axi_arready,
  output logic [31:0]                            s_axi_rdata,
  output logic [1:0]                             s_axi_rresp,
  output logic                                   s_axi_rvalid,
  input  logic                                   s_axi_rready,
  output logic                                   o_enable,
  output logic [PRESCALER_WIDTH-1:0]             o_prescale,
  output logic [NUM_CHANNELS-1:0][REG_WIDTH-1:0] o_period,
  output logic [NUM_CHANNELS-1:0][REG_WIDTH-1:0] o_duty
);

  localparam int CH_W = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;

  logic                                   r_live;
  logic                                   r_aw_held;
  logic                                   r_w_held;
  logic [ADDR_WIDTH-1:0]                  r_awaddr;
  logic [31:0]                            r_wdata;
  logic [3:0]                             r_wstrb;
  wr_state_e                              r_wstate;
  wr_state_e                              w_wstate_nxt;
  logic [1:0]                             r_bresp;
  rd_state_e                              r_rstate;
  rd_state_e                              w_rstate_nxt;
  logic [31:0]                            r_rdata;
  logic [1:0]                             r_rresp;

  logic                                   r_enable;
  logic [PRESCALER_WIDTH-1:0]             r_prescale;
  logic [NUM_CHANNELS-1:0][REG_WIDTH-1:0] r_period;
  logic [NUM_CHANNELS-1:0][REG_WIDTH-1:0] r_duty;

  logic                                   w_aw_acc;
  logic                                   w_w_acc;
  logic                                   w_commit;
  logic                                   w_b_hs;
  logic                                   w_ar_acc;
  logic [ADDR_WIDTH-1:0]                  w_wr_addr;
  logic [31:0]                            w_wr_data;
  logic [3:0]                             w_wr_strb;
  reg_sel_e                               w_wr_sel;
  logic [CH_W-1:0]                        w_wr_ch;
  logic                                   w_wr_valid;
  logic                                   w_wr_ok;
  reg_sel_e                               w_rd_sel;
  logic [CH_W-1:0]                        w_rd_ch;
  logic                                   w_rd_valid;
  logic [31:0]                            w_wr_old;
  logic [31:0]                            w_wr_merged;
  logic [31:0]                            w_rd_value;

  // Readies stay low while reset is asserted and rise one cycle after release.
  always_ff @(posedge i_clk or negedge i_resetn) begin
    if (!i_resetn) r_live <= 1'b0;
    else           r_live <= 1'b1;
  end

  assign w_aw_acc  = s_axi_awvalid && s_axi_awready;
  assign w_w_acc   = s_axi_wvalid && s_axi_wready;
  assign w_b_hs    = s_axi_bvalid && s_axi_bready;
  assign w_ar_acc  = s_axi_arvalid && s_axi_arready;
  assign w_commit  = (r_aw_held || w_aw_acc) && (r_w_held || w_w_acc) && (r_wstate == W_IDLE);
  assign w_wr_addr = r_aw_held ? r_awaddr : s_axi_awaddr;
  assign w_wr_data = r_w_held  ? r_wdata  : s_axi_wdata;
  assign w_wr_strb = r_w_held  ? r_wstrb  : s_axi_wstrb;
  assign w_wr_ok   = w_wr_valid && (w_wr_sel != SEL_INFO);

  pwm_reg_decode #(
    .ADDR_WIDTH  (ADDR_WIDTH),
    .NUM_CHANNELS(NUM_CHANNELS),
    .CH_W        (CH_W)
  ) u_wr_dec (
    .i_addr (w_wr_addr),
    .o_sel  (w_wr_sel),
    .o_ch   (w_wr_ch),
    .o_valid(w_wr_valid)
  );

  pwm_reg_decode #(
    .ADDR_WIDTH  (ADDR_WIDTH),
    .NUM_CHANNELS(NUM_CHANNELS),
    .CH_W        (CH_W)
  ) u_rd_dec (
    .i_addr (s_axi_araddr),
    .o_sel  (w_rd_sel),
    .o_ch   (w_rd_ch),
    .o_valid(w_rd_valid)
  );

  always_ff @(posedge i_clk or negedge i_resetn) begin
    if (!i_resetn) begin
      r_aw_held <= 1'b0;
      r_w_held  <= 1'b0;
      r_awaddr  <= '0;
      r_wdata   <= '0;
      r_wstrb   <= '0;
    end else if (w_b_hs) begin
      r_aw_held <= 1'b0;
      r_w_held  <= 1'b0;
    end else begin
      if (w_aw_acc) begin
        r_aw_held <= 1'b1;
        r_awaddr  <= s_axi_awaddr;
      end
      if (w_w_acc) begin
        r_w_held <= 1'b1;
        r_wdata  <= s_axi_wdata;
        r_wstrb  <= s_axi_wstrb;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_resetn) begin
    if (!i_resetn) begin
      r_wstate <= W_IDLE;
      r_bresp  <= RESP_OKAY;
    end else begin
      r_wstate <= w_wstate_nxt;
      if (w_commit) r_bresp <= w_wr_ok ? RESP_OKAY : RESP_SLVERR;
    end
  end

  always_comb begin
    w_wstate_nxt = r_wstate;
    case (r_wstate)
      W_IDLE:  if (w_commit) w_wstate_nxt = W_RESP;
      W_RESP:  if (s_axi_bready) w_wstate_nxt = W_IDLE;
      default: w_wstate_nxt = W_IDLE;
    endcase
  end

  always_comb begin
    s_axi_awready = r_live && !r_aw_held;
    s_axi_wready  = r_live && !r_w_held;
    s_axi_bvalid  = (r_wstate == W_RESP);
    s_axi_bresp   = r_bresp;
  end

  always_comb begin
    w_wr_old = '0;
    case (w_wr_sel)
      SEL_CTRL:     w_wr_old = 32'(r_enable);
      SEL_PRESCALE: w_wr_old = 32'(r_prescale);
      SEL_PERIOD:   w_wr_old = 32'(r_period[w_wr_ch]);
      SEL_DUTY:     w_wr_old = 32'(r_duty[w_wr_ch]);
      default:      w_wr_old = '0;
    endcase
    w_wr_merged = f_apply_wstrb(w_wr_old, w_wr_data, w_wr_strb);
  end

  always_ff @(posedge i_clk or negedge i_resetn) begin
    if (!i_resetn) begin
      r_enable   <= 1'b0;
      r_prescale <= '0;
      r_period   <= '0;
      r_duty     <= '0;
    end else if (w_commit && w_wr_ok) begin
      case (w_wr_sel)
        SEL_CTRL:     r_enable            <= w_wr_merged[0];
        SEL_PRESCALE: r_prescale          <= PRESCALER_WIDTH'(w_wr_merged);
        SEL_PERIOD:   r_period[w_wr_ch]   <= REG_WIDTH'(w_wr_merged);
        SEL_DUTY:     r_duty[w_wr_ch]     <= REG_WIDTH'(w_wr_merged);
        default:      ;
      endcase
    end
  end

  assign o_enable = r_enable;

`ifdef PWM_REGS_SHADOW_EN
  logic                                   r_out_prescale_vld;
  logic [PRESCALER_WIDTH-1:0]             r_out_prescale;
  logic [NUM_CHANNELS-1:0][REG_WIDTH-1:0] r_out_period;
  logic [NUM_CHANNELS-1:0][REG_WIDTH-1:0] r_out_duty;
  logic                                   w_apply;

  // The bus-visible registers act as shadows; COMMIT copies all of them at once.
  assign w_apply = w_commit && w_wr_ok && (w_wr_sel == SEL_CTRL) && w_wr_merged[1];

  always_ff @(posedge i_clk or negedge i_resetn) begin
    if (!i_resetn) begin
      r_out_prescale_vld <= 1'b0;
      r_out_prescale     <= '0;
      r_out_period       <= '0;
      r_out_duty         <= '0;
    end else if (w_apply) begin
      r_out_prescale_vld <= 1'b1;
      r_out_prescale     <= r_prescale;
      r_out_period       <= r_period;
      r_out_duty         <= r_duty;
    end
  end

  assign o_prescale = r_out_prescale;
  assign o_period   = r_out_period;
  assign o_duty     = r_out_duty;
`else
  assign o_prescale = r_prescale;
  assign o_period   = r_period;
  assign o_duty     = r_duty;
`endif

  always_comb begin
    w_rd_value = '0;
    case (w_rd_sel)
      SEL_CTRL:     w_rd_value = 32'(r_enable);
      SEL_PRESCALE: w_rd_value = 32'(r_prescale);
      SEL_INFO:     w_rd_value = {16'h0000, 8'(REG_WIDTH), 8'(NUM_CHANNELS)};
      SEL_PERIOD:   w_rd_value = 32'(r_period[w_rd_ch]);
      SEL_DUTY:     w_rd_value = 32'(r_duty[w_rd_ch]);
      default:      w_rd_value = '0;
    endcase
  end

  // Sampling at the AR handshake makes a same-cycle write invisible to this read.
  always_ff @(posedge i_clk or negedge i_resetn) begin
    if (!i_resetn) begin
      r_rstate <= R_IDLE;
      r_rdata  <= '0;
      r_rresp  <= RESP_OKAY;
    end else begin
      r_rstate <= w_rstate_nxt;
      if (w_ar_acc) begin
        r_rdata <= w_rd_value;
        r_rresp <= w_rd_valid ? RESP_OKAY : RESP_SLVERR;
      end
    end
  end

  always_comb begin
    w_rstate_nxt = r_rstate;
    case (r_rstate)
      R_IDLE:  if (w_ar_acc) w_rstate_nxt = R_DATA;
      R_DATA:  if (s_axi_rready) w_rstate_nxt = R_IDLE;
      default: w_rstate_nxt = R_IDLE;
    endcase
  end

  always_comb begin
    s_axi_arready = r_live && (r_rstate == R_IDLE);
    s_axi_rvalid  = (r_rstate == R_DATA);
    s_axi_rdata   = r_rdata;
    s_axi_rresp   = r_rresp;
  end

endmodule
`default_nettype wire

// File: tb/tb_pwm_axi_regs.sv
`default_nettype none
// +---------------------------------------------------------------------+
// | tb_pwm_axi_regs : randomized AXI4-Lite traffic against a register-   |
// |                   map reference model of pwm_axi_regs.               |
// | Revision: 1.0                                                        |
// +---------------------------------------------------------------------+
module tb_pwm_axi_regs;

  localparam int NCH = 4;
  localparam int RW  = 16;
  localparam int PW  = 16;
  localparam int AW  = 8;
`ifdef PWM_REGS_SHADOW_EN
  localparam bit SHADOW = 1'b1;
`else
  localparam bit SHADOW = 1'b0;
`endif
  localparam bit [31:0] RMASK = 32'((64'd1 << RW) - 1);
  localparam bit [31:0] PMASK = 32'((64'd1 << PW) - 1);

  logic                    clk = 1'b0;
  logic                    resetn = 1'b0;
  logic [AW-1:0]           awaddr = '0, araddr = '0;
  logic                    awvalid = 0, wvalid = 0, bready = 0, arvalid = 0, rready = 0;
  logic [31:0]             wdata = '0;
  logic [3:0]              wstrb = '0;
  logic                    awready, wready, bvalid, arready, rvalid, o_enable;
  logic [1:0]              bresp, rresp;
  logic [31:0]             rdata;
  logic [PW-1:0]           o_prescale;
  logic [NCH-1:0][RW-1:0]  o_period, o_duty;

  always #5 clk = ~clk;

  pwm_axi_regs #(
    .NUM_CHANNELS(NCH), .REG_WIDTH(RW), .PRESCALER_WIDTH(PW), .ADDR_WIDTH(AW)
  ) dut (
    .i_clk(clk), .i_resetn(resetn),
    .s_axi_awaddr(awaddr), .s_axi_awvalid(awvalid), .s_axi_awready(awready),
    .s_axi_wdata(wdata), .s_axi_wstrb(wstrb), .s_axi_wvalid(wvalid), .s_axi_wready(wready),
    .s_axi_bresp(bresp), .s_axi_bvalid(bvalid), .s_axi_bready(bready),
    .s_axi_araddr(araddr), .s_axi_arvalid(arvalid), .s_axi_arready(arready),
    .s_axi_rdata(rdata), .s_axi_rresp(rresp), .s_axi_rvalid(rvalid), .s_axi_rready(rready),
    .o_enable(o_enable), .o_prescale(o_prescale), .o_period(o_period), .o_duty(o_duty)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Reference model: bus-visible values and what the core should currently see.
  bit        m_en;
  bit [31:0] m_pre, q_pre;
  bit [31:0] m_per[NCH], m_duty[NCH], q_per[NCH], q_duty[NCH];

  function automatic bit [31:0] merge(input bit [31:0] old, input bit [31:0] d, input bit [3:0] s);
    bit [31:0] v = old;
    for (int b = 0; b < 4; b++) if (s[b]) v[8*b +: 8] = d[8*b +: 8];
    return v;
  endfunction

  task automatic model_reset();
    m_en = 0; m_pre = 0; q_pre = 0;
    for (int c = 0; c < NCH; c++) begin
      m_per[c] = 0; m_duty[c] = 0; q_per[c] = 0; q_duty[c] = 0;
    end
  endtask

  task automatic model_apply();
    q_pre = m_pre;
    for (int c = 0; c < NCH; c++) begin
      q_per[c] = m_per[c]; q_duty[c] = m_duty[c];
    end
  endtask

  task automatic model_read(input bit [AW-1:0] a, output bit [31:0] v, output bit [1:0] resp);
    int off = int'(a) & 'hFC;
    resp = 2'b00;
    v = 0;
    if (off == 'h00)      v = 32'(m_en);
    else if (off == 'h04) v = m_pre;
    else if (off == 'h0C) v = (RW << 8) | NCH;
    else if (off >= 'h10 && off < 'h10 + 8 * NCH)
      v = (((off - 'h10) % 8) == 0) ? m_per[(off - 'h10) / 8] : m_duty[(off - 'h10) / 8];
    else resp = 2'b10;
  endtask

  task automatic model_write(input bit [AW-1:0] a, input bit [31:0] d, input bit [3:0] s,
                             output bit [1:0] resp);
    int off = int'(a) & 'hFC;
    bit [31:0] v;
    resp = 2'b00;
    if (off == 'h00) begin
      v = merge(32'(m_en), d, s);
      m_en = v[0];
      if (SHADOW && s[0] && d[1]) model_apply();
    end else if (off == 'h04) begin
      m_pre = merge(m_pre, d, s) & PMASK;
    end else if (off >= 'h10 && off < 'h10 + 8 * NCH) begin
      if (((off - 'h10) % 8) == 0) m_per[(off - 'h10) / 8] = merge(m_per[(off - 'h10) / 8], d, s) & RMASK;
      else m_duty[(off - 'h10) / 8] = merge(m_duty[(off - 'h10) / 8], d, s) & RMASK;
    end else begin
      resp = 2'b10;
    end
    if (!SHADOW) model_apply();
  endtask

  task automatic check_outputs(input string where);
    check_eq({where, ":o_enable"}, 32'(o_enable), 32'(m_en));
    check_eq({where, ":o_prescale"}, 32'(o_prescale), q_pre);
    for (int c = 0; c < NCH; c++) begin
      check_eq($sformatf("%s:o_period[%0d]", where, c), 32'(o_period[c]), q_per[c]);
      check_eq($sformatf("%s:o_duty[%0d]", where, c), 32'(o_duty[c]), q_duty[c]);
    end
  endtask

  // All driving and sampling happens on the falling edge.
  task automatic axi_write(input bit [AW-1:0] a, input bit [31:0] d, input bit [3:0] s,
                           input int aw_dly, input int w_dly, input int b_dly);
    int cyc = 0;
    bit aw_ok = 0, w_ok = 0, early = 0;
    bit [1:0] exp_resp;
    while (!(aw_ok && w_ok) && cyc < 40) begin
      awaddr = a; wdata = d; wstrb = s;
      awvalid = !aw_ok && (cyc >= aw_dly);
      wvalid  = !w_ok && (cyc >= w_dly);
      if (bvalid) early = 1;
      if (awvalid && awready) aw_ok = 1;
      if (wvalid && wready) w_ok = 1;
      @(posedge clk); @(negedge clk);
      cyc++;
    end
    awvalid = 0; wvalid = 0;
    check_eq($sformatf("wr_accept@%02h", a), {30'd0, aw_ok, w_ok}, 32'd3);
    check_eq("bvalid_early", 32'(early), 0);
    model_write(a, d, s, exp_resp);
    check_eq($sformatf("bvalid_lat@%02h", a), 32'(bvalid), 1);
    check_eq($sformatf("bresp@%02h", a), 32'(bresp), 32'(exp_resp));
    check_outputs($sformatf("wr@%02h", a));
    repeat (b_dly) begin
      @(posedge clk); @(negedge clk);
      check_eq("bvalid_hold", 32'(bvalid), 1);
      check_eq("awready_blocked", 32'(awready), 0);
    end
    bready = 1;
    @(posedge clk); @(negedge clk);
    bready = 0;
    check_eq("bvalid_clear", 32'(bvalid), 0);
  endtask

  task automatic axi_read(input bit [AW-1:0] a, input int ar_dly, input int r_dly,
                          output bit [31:0] got);
    int cyc = 0;
    bit ar_ok = 0, early = 0;
    bit [31:0] exp_v;
    bit [1:0] exp_resp;
    model_read(a, exp_v, exp_resp);
    while (!ar_ok && cyc < 40) begin
      araddr = a;
      arvalid = (cyc >= ar_dly);
      if (rvalid) early = 1;
      if (arvalid && arready) ar_ok = 1;
      @(posedge clk); @(negedge clk);
      cyc++;
    end
    arvalid = 0;
    check_eq($sformatf("rd_accept@%02h", a), 32'(ar_ok), 1);
    check_eq("rvalid_early", 32'(early), 0);
    check_eq($sformatf("rvalid_lat@%02h", a), 32'(rvalid), 1);
    check_eq($sformatf("rdata@%02h", a), rdata, exp_v);
    check_eq($sformatf("rresp@%02h", a), 32'(rresp), 32'(exp_resp));
    got = rdata;
    repeat (r_dly) begin
      @(posedge clk); @(negedge clk);
      check_eq("rdata_hold", rdata, exp_v);
      check_eq("arready_blocked", 32'(arready), 0);
    end
    rready = 1;
    @(posedge clk); @(negedge clk);
    rready = 0;
    check_eq("rvalid_clear", 32'(rvalid), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  bit [AW-1:0] pool[16] = '{8'h00, 8'h04, 8'h08, 8'h0C, 8'h10, 8'h14, 8'h18, 8'h1C,
                            8'h20, 8'h24, 8'h28, 8'h2C, 8'h30, 8'h80, 8'h06, 8'h17};

  initial begin
    bit [31:0] got, old_v, d;
    bit [1:0] r_resp_exp, b_resp_exp;
    bit [AW-1:0] a;

    model_reset();
    repeat (3) @(negedge clk);
    check_eq("rst_awready", 32'(awready), 0);
    check_eq("rst_wready", 32'(wready), 0);
    check_eq("rst_arready", 32'(arready), 0);
    check_eq("rst_bvalid", 32'(bvalid), 0);
    check_eq("rst_rvalid", 32'(rvalid), 0);
    check_eq("rst_resp", {28'd0, bresp, rresp}, 0);
    check_outputs("rst");
    resetn = 1;
    @(posedge clk); @(negedge clk);
    check_eq("live_readies", {29'd0, awready, wready, arready}, 32'd7);

    axi_read(8'h0C, 0, 0, got);
    check_eq("info_value", got, 32'h0000_1004);

    if (SHADOW) begin
      axi_write(8'h14, 32'd5, 4'hF, 0, 0, 0);
      check_eq("shadow_duty_hold", 32'(o_duty[0]), 0);
      axi_write(8'h00, 32'h3, 4'hF, 0, 0, 0);
      check_eq("shadow_duty_commit", 32'(o_duty[0]), 5);
      check_eq("shadow_enable", 32'(o_enable), 1);
    end

    axi_write(8'h20, 32'd9, 4'hF, 0, 3, 0);
    axi_read(8'h20, 0, 0, got);
    check_eq("period2_readback", got, 32'd9);

    axi_write(8'h04, 32'hABCD_1234, 4'b0001, 1, 0, 0);
    axi_read(8'h04, 0, 2, got);
    check_eq("prescale_strobe", got, 32'h0000_0034);

    axi_read(8'h80, 0, 0, got);
    axi_write(8'h0C, 32'hFFFF_FFFF, 4'hF, 0, 0, 0);
    axi_read(8'h0C, 0, 0, got);
    check_eq("info_unchanged", got, 32'h0000_1004);

    axi_write(8'h1C, 32'h0000_BEEF, 4'hF, 2, 0, 5);

    // Read and write to the same register committing on the same edge.
    model_read(8'h18, old_v, r_resp_exp);
    d = $urandom;
    awaddr = 8'h18; araddr = 8'h18; wdata = d; wstrb = 4'hF;
    awvalid = 1; wvalid = 1; arvalid = 1;
    @(posedge clk); @(negedge clk);
    awvalid = 0; wvalid = 0; arvalid = 0;
    check_eq("same_cycle_rdata", rdata, old_v);
    check_eq("same_cycle_rvalid", 32'(rvalid), 1);
    model_write(8'h18, d, 4'hF, b_resp_exp);
    check_eq("same_cycle_bvalid", 32'(bvalid), 1);
    check_outputs("same_cycle");
    bready = 1; rready = 1;
    @(posedge clk); @(negedge clk);
    bready = 0; rready = 0;
    check_eq("same_cycle_done", {30'd0, bvalid, rvalid}, 0);

    for (int i = 0; i < 80; i++) begin
      a = pool[$urandom_range(0, 15)];
      case ($urandom_range(0, 2))
        0: axi_read(a, $urandom_range(0, 3), $urandom_range(0, 2), got);
        1: axi_write(a, $urandom, 4'($urandom_range(0, 15)), $urandom_range(0, 3),
                     $urandom_range(0, 3), $urandom_range(0, 2));
        default: begin
          axi_write(a, $urandom, 4'hF, $urandom_range(0, 2), $urandom_range(0, 2), 0);
          axi_read(a, 0, 0, got);
        end
      endcase
    end
    axi_write(8'h00, 32'h3, 4'h1, 0, 0, 0);

    // Reset while a write response is pending aborts everything.
    awaddr = 8'h10; wdata = 32'h55; wstrb = 4'hF; awvalid = 1; wvalid = 1;
    @(posedge clk); @(negedge clk);
    awvalid = 0; wvalid = 0;
    check_eq("pre_abort_bvalid", 32'(bvalid), 1);
    resetn = 0;
    #1;
    model_reset();
    check_eq("abort_bvalid", 32'(bvalid), 0);
    check_eq("abort_awready", 32'(awready), 0);
    check_outputs("abort");
    @(negedge clk);
    resetn = 1;
    @(posedge clk); @(negedge clk);
    check_eq("abort_readies", {29'd0, awready, wready, arready}, 32'd7);
    axi_read(8'h10, 0, 0, got);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
